// File: rtl/spi_pkg.sv
// Shared SPI definitions used by the slave (and intended for the matching master).
//   SPI_DW       : word width carried by one transfer
//   SPI_CW       : width of a bit counter that can hold 0..SPI_DW
//   spi_state_e  : transfer state (IDLE while cs is high, ACTIVE while cs is low)
//   head_bit     : bit that leaves a shift register first for the chosen bit order
//   push_bit     : shift a register one place in the chosen bit order, inserting b
package spi_pkg;

   localparam int SPI_DW = 8;
   localparam int SPI_CW = $clog2(SPI_DW + 1);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } spi_state_e;

   function automatic logic head_bit(input logic [SPI_DW-1:0] sr, input logic msb_first);
      return msb_first ? sr[SPI_DW-1] : sr[0];
   endfunction

   // MSB-first shifts left and fills at bit 0; LSB-first shifts right and fills at the top.
   function automatic logic [SPI_DW-1:0] push_bit(input logic [SPI_DW-1:0] sr,
                                                  input logic              b,
                                                  input logic              msb_first);
      return msb_first ? {sr[SPI_DW-2:0], b} : {b, sr[SPI_DW-1:1]};
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer with rise/fall pulse detection on the synchronized copy.
//   clk, resetn : system clock, asynchronous active-low reset
//   d_in        : asynchronous input pin
//   q           : synchronized level
//   rise, fall  : one-cycle pulses on synchronized transitions
// The sync chain and the edge-history flop both reset to RST_VAL. Edges are masked
// until the whole chain has been refilled from the pin after reset, so a pin that
// already differs from RST_VAL when reset releases does not produce a false edge.
module spi_sync_edge #(
   parameter int   SYNC_N  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic resetn,
   input  logic d_in,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [SYNC_N-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;
   logic [SYNC_N:0]   fill_q, fill_d;

   always_comb begin
      sync_d = {sync_q[SYNC_N-2:0], d_in};
      prev_d = sync_q[SYNC_N-1];
      fill_d = {fill_q[SYNC_N-1:0], 1'b1};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_q <= {SYNC_N{RST_VAL}};
         prev_q <= RST_VAL;
         fill_q <= '0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
         fill_q <= fill_d;
      end
   end

   assign q    = sync_q[SYNC_N-1];
   assign rise = fill_q[SYNC_N] &  q & ~prev_q;
   assign fall = fill_q[SYNC_N] & ~q &  prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave, all four cpol/cpha modes, selectable bit order, back-to-back bytes.
//   clk, resetn          : system clock, asynchronous active-low reset
//   cpol, cpha, msb_lsb  : mode/bit order, latched at each cs falling edge
//   tx_data, tx_ack      : byte to send; tx_ack pulses when it is captured
//   rx_data, rx_valid    : last complete received byte; rx_valid pulses on update
//   sck, cs, sdi, sdo    : SPI pins (sck/cs/sdi asynchronous, sdo registered)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | cs high; sdo held 0, sck ignored, waiting for cs falling edge
// ST_ACTIVE | cs low; sampling sdi / shifting sdo on the latched sck edges
module spi_slave
   import spi_pkg::*;
#(
   parameter int SYNC_N = 2
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              msb_lsb,
   input  logic [SPI_DW-1:0] tx_data,
   output logic              tx_ack,
   output logic [SPI_DW-1:0] rx_data,
   output logic              rx_valid,
   input  logic              sck,
   input  logic              cs,
   input  logic              sdi,
   output logic              sdo
);

   logic sck_lvl, sck_rise, sck_fall;
   logic cs_lvl, cs_rise, cs_fall;
   logic sdi_s, sdi_rise, sdi_fall;
   logic unused_sync;

   spi_sync_edge #(.SYNC_N(SYNC_N), .RST_VAL(1'b0)) u_sync_sck (
      .clk(clk), .resetn(resetn), .d_in(sck), .q(sck_lvl), .rise(sck_rise), .fall(sck_fall)
   );
   spi_sync_edge #(.SYNC_N(SYNC_N), .RST_VAL(1'b1)) u_sync_cs (
      .clk(clk), .resetn(resetn), .d_in(cs), .q(cs_lvl), .rise(cs_rise), .fall(cs_fall)
   );
   spi_sync_edge #(.SYNC_N(SYNC_N), .RST_VAL(1'b0)) u_sync_sdi (
      .clk(clk), .resetn(resetn), .d_in(sdi), .q(sdi_s), .rise(sdi_rise), .fall(sdi_fall)
   );

   assign unused_sync = sck_lvl ^ cs_lvl ^ sdi_rise ^ sdi_fall;

   spi_state_e        state_q, state_d;
   logic              cpol_q, cpol_d;
   logic              cpha_q, cpha_d;
   logic              msb_q, msb_d;
   logic [SPI_CW-1:0] cnt_q, cnt_d;
   logic [SPI_DW-1:0] rx_sr_q, rx_sr_d;
   logic [SPI_DW-1:0] tx_sr_q, tx_sr_d;
   logic [SPI_DW-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              tx_ack_q, tx_ack_d;
   logic              sdo_q, sdo_d;

   logic              lead_edge, trail_edge, sample_edge, shift_edge;
   logic [SPI_DW-1:0] rx_next;

   // Edge roles come from the latched mode so mid-transfer pin changes are ignored.
   assign lead_edge   = cpol_q ? sck_fall : sck_rise;
   assign trail_edge  = cpol_q ? sck_rise : sck_fall;
   assign sample_edge = cpha_q ? trail_edge : lead_edge;
   assign shift_edge  = cpha_q ? lead_edge  : trail_edge;
   assign rx_next     = push_bit(rx_sr_q, sdi_s, msb_q);

   always_comb begin
      state_d    = state_q;
      cpol_d     = cpol_q;
      cpha_d     = cpha_q;
      msb_d      = msb_q;
      cnt_d      = cnt_q;
      rx_sr_d    = rx_sr_q;
      tx_sr_d    = tx_sr_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      tx_ack_d   = 1'b0;
      sdo_d      = sdo_q;

      case (state_q)
         ST_IDLE: begin
            sdo_d = 1'b0;
            cnt_d = '0;
            if (cs_fall) begin
               state_d  = ST_ACTIVE;
               cpol_d   = cpol;
               cpha_d   = cpha;
               msb_d    = msb_lsb;
               rx_sr_d  = '0;
               tx_ack_d = 1'b1;
               // cpha=0: first bit must be on the wire before the first (sampling) edge.
               if (cpha) begin
                  tx_sr_d = tx_data;
               end else begin
                  sdo_d   = head_bit(tx_data, msb_lsb);
                  tx_sr_d = push_bit(tx_data, 1'b0, msb_lsb);
               end
            end
         end

         ST_ACTIVE: begin
            if (sample_edge) begin
               rx_sr_d = rx_next;
               if (cnt_q == SPI_CW'(SPI_DW - 1)) begin
                  cnt_d      = '0;
                  rx_data_d  = rx_next;
                  rx_valid_d = 1'b1;
                  // Full reload: the next shift edge presents the new byte's first bit.
                  tx_sr_d    = tx_data;
                  tx_ack_d   = ~cs_rise;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (shift_edge) begin
               sdo_d   = head_bit(tx_sr_q, msb_q);
               tx_sr_d = push_bit(tx_sr_q, 1'b0, msb_q);
            end

            // A byte completing in the same cycle still delivers rx_valid above.
            if (cs_rise) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               sdo_d   = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
         msb_q      <= 1'b1;
         cnt_q      <= '0;
         rx_sr_q    <= '0;
         tx_sr_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         tx_ack_q   <= 1'b0;
         sdo_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cpol_q     <= cpol_d;
         cpha_q     <= cpha_d;
         msb_q      <= msb_d;
         cnt_q      <= cnt_d;
         rx_sr_q    <= rx_sr_d;
         tx_sr_q    <= tx_sr_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         tx_ack_q   <= tx_ack_d;
         sdo_q      <= sdo_d;
      end
   end

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign tx_ack   = tx_ack_q;
   assign sdo      = sdo_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a behavioural SPI master drives the pins; expected slave
// rx bytes are queued when a transfer is issued and checked by an rx_valid monitor;
// bytes captured on tx_ack are queued and checked against what the master shifts in.
module tb_spi_slave;

   localparam int SYNC_N = 2;

   logic       clk;
   logic       resetn;
   logic       cpol, cpha, msb_lsb;
   logic [7:0] tx_data;
   logic       tx_ack;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       sck, cs, sdi;
   logic       sdo;

   spi_slave #(.SYNC_N(SYNC_N)) dut (
      .clk(clk), .resetn(resetn), .cpol(cpol), .cpha(cpha), .msb_lsb(msb_lsb),
      .tx_data(tx_data), .tx_ack(tx_ack), .rx_data(rx_data), .rx_valid(rx_valid),
      .sck(sck), .cs(cs), .sdi(sdi), .sdo(sdo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] exp_rx[$];     // bytes the slave must report on rx_valid
   logic [7:0] exp_mrx[$];    // bytes the slave captured, in the order it must send them
   logic [7:0] m_rx_log[$];   // bytes the master shifted in during the last transfer
   logic [7:0] m_tx[4];
   logic [7:0] last_rx;
   logic [7:0] next_tx;
   bit         next_tx_fixed;
   int         n_rxv = 0;
   int         n_ack = 0;
   time        t_samp = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic mbit(input logic [7:0] b, input int k, input logic msb);
      return msb ? b[7-k] : b[k];
   endfunction

   // rx_valid monitor
   initial begin
      forever begin
         @(negedge clk);
         if (resetn && rx_valid) begin
            n_rxv++;
            if (exp_rx.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL rx_valid_unexpected: got pulse with rx_data=%0h, expected no pulse", rx_data);
            end else begin
               check("rx_data", rx_data, exp_rx.pop_front());
               check("rx_latency_le_sync_n_plus_2",
                     32'((($time - t_samp) / 10) <= (SYNC_N + 2)), 32'd1);
            end
         end
      end
   end

   // tx_ack monitor: record the captured byte, then present a new one
   initial begin
      forever begin
         @(negedge clk);
         if (resetn && tx_ack) begin
            n_ack++;
            exp_mrx.push_back(tx_data);
            tx_data = next_tx_fixed ? next_tx : 8'($urandom);
            next_tx_fixed = 1'b0;
         end
      end
   end

   task automatic master_sample(input logic m_msb, input int k, inout logic [7:0] rxb);
      rxb[m_msb ? 7 - k : k] = sdo;
      if (k == 7) begin
         t_samp = $time;
         m_rx_log.push_back(rxb);
         if (exp_mrx.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL master_rx: got %0h, expected a byte announced by tx_ack (none)", rxb);
         end else begin
            check("master_rx", rxb, exp_mrx.pop_front());
         end
      end
   endtask

   // Behavioural master. abort_bits < 0 means nbytes full bytes; otherwise that many
   // sck cycles are clocked and cs is released. cs_with_edge raises cs together with
   // the final trailing edge. scramble changes the mode pins after the transfer starts.
   task automatic spi_xfer(input logic m_cpol, input logic m_cpha, input logic m_msb,
                           input int nbytes, input int half, input int abort_bits,
                           input bit cs_with_edge, input bit scramble);
      int         total;
      int         rxv0;
      logic [7:0] rxb;
      total = (abort_bits >= 0) ? abort_bits : nbytes * 8;
      for (int j = 0; j < total / 8; j++) exp_rx.push_back(m_tx[j]);
      m_rx_log.delete();
      rxv0 = n_rxv;
      cpol = m_cpol; cpha = m_cpha; msb_lsb = m_msb;
      sck = m_cpol; cs = 1'b1;
      wait_clk(half);
      cs = 1'b0;
      if (!m_cpha) sdi = mbit(m_tx[0], 0, m_msb);
      wait_clk(half);
      if (scramble) begin
         cpol = 1'($urandom); cpha = 1'($urandom); msb_lsb = 1'($urandom);
      end
      rxb = '0;
      for (int i = 0; i < total; i++) begin
         if (m_cpha) sdi = mbit(m_tx[i/8], i % 8, m_msb);
         if (!m_cpha) master_sample(m_msb, i % 8, rxb);
         sck = ~m_cpol;
         wait_clk(half);
         if (m_cpha) master_sample(m_msb, i % 8, rxb);
         sck = m_cpol;
         if (cs_with_edge && i == total - 1) cs = 1'b1;
         if (!m_cpha && i < total - 1) sdi = mbit(m_tx[(i+1)/8], (i + 1) % 8, m_msb);
         wait_clk(half);
      end
      cs = 1'b1;
      wait_clk(half + 6);
      exp_mrx.delete();
      if (total / 8 > 0) last_rx = m_tx[total/8 - 1];
      check("rx_valid_count", 32'(n_rxv - rxv0), 32'(total / 8));
      check("rx_pending_empty", 32'(exp_rx.size()), 32'd0);
      check("sdo_idle_zero", 32'(sdo), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      int ack0;
      int rxv0;
      resetn = 1'b0;
      cpol = 1'b0; cpha = 1'b0; msb_lsb = 1'b1;
      tx_data = 8'h00; next_tx = 8'h00; next_tx_fixed = 1'b0;
      sck = 1'b0; cs = 1'b1; sdi = 1'b0;
      last_rx = 8'h00;
      wait_clk(4);
      check("reset_rx_data", rx_data, 8'h00);
      check("reset_rx_valid", rx_valid, 1'b0);
      check("reset_tx_ack", tx_ack, 1'b0);
      check("reset_sdo", sdo, 1'b0);
      resetn = 1'b1;
      wait_clk(8);

      // Mode 0, MSB first: A5 in, 3C out
      tx_data = 8'h3C;
      m_tx[0] = 8'hA5;
      spi_xfer(1'b0, 1'b0, 1'b1, 1, 6, -1, 1'b0, 1'b0);
      check("s1_rx_data", rx_data, 8'hA5);
      check("s1_master_rx", m_rx_log.size() > 0 ? m_rx_log[0] : 8'hxx, 8'h3C);

      // All four modes, LSB first, 01 in; fixed tx byte checks sdo bit order
      for (int md = 0; md < 4; md++) begin
         tx_data = 8'h01 << md;
         m_tx[0] = 8'h01;
         spi_xfer(1'(md >> 1), 1'(md), 1'b0, 1, 5, -1, 1'b0, 1'b0);
         check("s2_rx_data", rx_data, 8'h01);
         check("s2_master_rx", m_rx_log.size() > 0 ? m_rx_log[0] : 8'hxx, 32'(8'h01 << md));
      end

      // Back-to-back: 12 then 34, slave sends 5A then C3 (changed after first tx_ack)
      tx_data = 8'h5A; next_tx = 8'hC3; next_tx_fixed = 1'b1;
      m_tx[0] = 8'h12; m_tx[1] = 8'h34;
      spi_xfer(1'b1, 1'b0, 1'b1, 2, 6, -1, 1'b0, 1'b0);
      check("s3_rx_data", rx_data, 8'h34);
      check("s3_master_rx0", m_rx_log.size() > 1 ? m_rx_log[0] : 8'hxx, 8'h5A);
      check("s3_master_rx1", m_rx_log.size() > 1 ? m_rx_log[1] : 8'hxx, 8'hC3);

      // Abort after 5 sck cycles, then a full FF byte
      m_tx[0] = 8'h6E;
      spi_xfer(1'b0, 1'b1, 1'b1, 1, 5, 5, 1'b0, 1'b0);
      check("s4_abort_rx_unchanged", rx_data, 8'h34);
      m_tx[0] = 8'hFF;
      spi_xfer(1'b0, 1'b1, 1'b1, 1, 5, -1, 1'b0, 1'b0);
      check("s4_rx_ff", rx_data, 8'hFF);

      // cs rise detected together with the 8th sample edge: byte completes, no reload ack
      m_tx[0] = 8'h96;
      ack0 = n_ack;
      spi_xfer(1'b1, 1'b1, 1'b0, 1, 4, -1, 1'b1, 1'b0);
      check("s5_rx_data", rx_data, 8'h96);
      check("s5_ack_count", 32'(n_ack - ack0), 32'd1);

      // Reset mid-byte with cs held low
      tx_data = 8'hFF;
      cpol = 1'b0; cpha = 1'b0; msb_lsb = 1'b1; sck = 1'b0; sdi = 1'b1;
      cs = 1'b0;
      wait_clk(6);
      for (int i = 0; i < 3; i++) begin
         sck = 1'b1; wait_clk(6);
         sck = 1'b0; wait_clk(6);
      end
      resetn = 1'b0;
      #1;
      check("s6_reset_rx_data", rx_data, 8'h00);
      check("s6_reset_rx_valid", rx_valid, 1'b0);
      check("s6_reset_tx_ack", tx_ack, 1'b0);
      check("s6_reset_sdo", sdo, 1'b0);
      wait_clk(3);
      exp_mrx.delete();
      resetn = 1'b1;
      last_rx = 8'h00;
      rxv0 = n_rxv;
      ack0 = n_ack;
      for (int i = 0; i < 10; i++) begin
         sdi = 1'($urandom);
         sck = 1'b1; wait_clk(6);
         sck = 1'b0; wait_clk(6);
      end
      check("s6_no_rx_valid_after_reset", 32'(n_rxv - rxv0), 32'd0);
      check("s6_no_tx_ack_after_reset", 32'(n_ack - ack0), 32'd0);
      check("s6_rx_data_still_zero", rx_data, 8'h00);
      cs = 1'b1;
      wait_clk(8);
      exp_mrx.delete();
      m_tx[0] = 8'h3D;
      spi_xfer(1'b0, 1'b0, 1'b1, 1, 5, -1, 1'b0, 1'b0);
      check("s6_recover_rx", rx_data, 8'h3D);

      // Slowest clock
      m_tx[0] = 8'($urandom);
      spi_xfer(1'b1, 1'b0, 1'b1, 1, 255, -1, 1'b0, 1'b0);

      // Random transfers
      for (int t = 0; t < 100; t++) begin
         int nb;
         int ab;
         nb = $urandom_range(1, 3);
         for (int j = 0; j < 4; j++) m_tx[j] = 8'($urandom);
         ab = ($urandom_range(0, 9) == 0) ? $urandom_range(1, nb * 8 - 1) : -1;
         spi_xfer(1'($urandom), 1'($urandom), 1'($urandom), nb, $urandom_range(4, 12), ab,
                  1'($urandom), 1'($urandom));
         check("rand_rx_data_model", rx_data, last_rx);
      end

      check("final_rx_pending_empty", 32'(exp_rx.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
